// File: rtl/acc_counter_pkg.sv
// Shared definitions for the accumulator/counter unit.
// Op encoding and default datapath sizing.
package acc_counter_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ADD   = 2'b01,
        OP_ACC   = 2'b10,
        OP_COUNT = 2'b11
    } op_e;

    localparam int          DEF_WIDTH = 8;
    localparam int unsigned DEF_STEP  = 1;

endpackage

// File: rtl/acc_counter_alu.sv
// Combinational add/subtract with one guard bit.
// Guard bit flags carry-out (add) or borrow (sub); sat clamps the result.
module acc_counter_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    input  logic             sat,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [WIDTH:0] full;

    always_comb begin
        full = sub ? ({1'b0, x} - {1'b0, y})
                   : ({1'b0, x} + {1'b0, y});
        ovf  = full[WIDTH];
        res  = full[WIDTH-1:0];
        if (ovf && sat) begin
            res = sub ? '0 : '1;
        end
    end

endmodule

// File: rtl/acc_counter_unit.sv
// Accumulator / counter with a one-deep valid/ready output register.
// Holds acc state; arithmetic is delegated to acc_counter_alu.
module acc_counter_unit
    import acc_counter_pkg::*;
#(
    parameter int          WIDTH = DEF_WIDTH,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             dir,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    op_e              op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_res;
    logic             alu_sub;
    logic             alu_ovf;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_ovf;
    logic             upd_acc;
    logic             accept;

    assign op_q     = op_e'(op);
    assign in_ready = rst_n & en & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        alu_x   = acc;
        alu_y   = a;
        alu_sub = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_x = a;
                alu_y = b;
            end
            OP_COUNT: begin
                alu_y   = STEP_W;
                alu_sub = ~dir;
            end
            default: ;
        endcase
    end

    acc_counter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x   (alu_x),
        .y   (alu_y),
        .sub (alu_sub),
        .sat (sat),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    // LOAD bypasses the ALU; ADD is the only op that leaves acc alone
    always_comb begin
        nxt_res = alu_res;
        nxt_ovf = alu_ovf;
        upd_acc = (op_q != OP_ADD);
        if (op_q == OP_LOAD) begin
            nxt_res = a;
            nxt_ovf = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            result    <= nxt_res;
            ovf       <= nxt_ovf;
            out_valid <= 1'b1;
            if (upd_acc) begin
                acc <= nxt_res;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_counter_unit.sv
// Self-checking bench for acc_counter_unit (WIDTH=8 and WIDTH=16/STEP=3).
// Directed scenarios followed by randomized traffic against an arithmetic model.
module tb_acc_counter_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, in_valid, dir, sat, out_ready;
    logic [1:0] op;
    logic [7:0] a, b;
    logic       in_ready, out_valid, ovf;
    logic [7:0] result;

    logic        en16, v16, dir16, sat16, ordy16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        rdy16, ov16, ovf16;
    logic [15:0] res16;

    longint m_acc, m_res, m16_acc;
    bit     m_ovf, m_ov;
    int     nchk = 0;
    int     nerr = 0;

    always #5 clk = ~clk;

    acc_counter_unit #(.WIDTH(8), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .a(a), .b(b), .dir(dir),
        .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf)
    );

    acc_counter_unit #(.WIDTH(16), .STEP(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .in_valid(v16),
        .in_ready(rdy16), .op(op16), .a(a16), .b(b16), .dir(dir16),
        .sat(sat16), .out_valid(ov16), .out_ready(ordy16),
        .result(res16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic, then range check against 0..2^w-1
    function automatic void calc(input int w, input longint stp,
                                 input logic [1:0] o, input longint x,
                                 input longint y, input bit d, input bit s,
                                 inout longint acc, output longint r,
                                 output bit f);
        longint mx;
        longint v;
        mx = (longint'(1) << w) - 1;
        case (o)
            2'd0:    v = x;
            2'd1:    v = x + y;
            2'd2:    v = acc + x;
            default: v = d ? acc + stp : acc - stp;
        endcase
        f = (v > mx) || (v < 0);
        if (v > mx)     r = s ? mx : v - (mx + 1);
        else if (v < 0) r = s ? 0 : v + mx + 1;
        else            r = v;
        if (o != 2'd1) acc = r;
    endfunction

    task automatic step();
        bit     exp_rdy;
        longint r;
        bit     f;
        #1;
        exp_rdy = rst_n && en && (!m_ov || out_ready);
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (!rst_n) begin
            m_acc = 0; m_res = 0; m_ovf = 0; m_ov = 0;
        end else if (in_valid && exp_rdy) begin
            calc(8, 1, op, a, b, dir, sat, m_acc, r, f);
            m_res = r; m_ovf = f; m_ov = 1;
        end else if (out_ready) begin
            m_ov = 0;
        end
        #1;
        check("out_valid", out_valid, m_ov);
        check("result", result, m_res);
        check("ovf", ovf, m_ovf);
    endtask

    task automatic req(input logic [1:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic d, input logic s);
        in_valid = 1; op = o; a = aa; b = bb; dir = d; sat = s;
        en = 1; out_ready = 1;
        step();
        in_valid = 0;
    endtask

    task automatic step16(input logic [1:0] o, input logic [15:0] aa,
                          input logic d, input logic s);
        longint r;
        bit     f;
        v16 = 1; op16 = o; a16 = aa; dir16 = d; sat16 = s;
        @(posedge clk);
        calc(16, 3, o, aa, 0, d, s, m16_acc, r, f);
        #1;
        check("out_valid16", ov16, 1'b1);
        check("result16", res16, r);
        check("ovf16", ovf16, f);
        v16 = 0;
    endtask

    initial begin
        rst_n = 0; en = 0; in_valid = 0; op = 0; a = 0; b = 0;
        dir = 0; sat = 0; out_ready = 0;
        en16 = 1; v16 = 0; op16 = 0; a16 = 0; b16 = 0;
        dir16 = 0; sat16 = 0; ordy16 = 1;
        m_acc = 0; m_res = 0; m_ovf = 0; m_ov = 0; m16_acc = 0;

        in_valid = 1; en = 1;
        step();
        step();
        in_valid = 0;
        rst_n = 1;
        step();

        // wrap on count-up
        req(2'd0, 8'hFE, 0, 0, 0);
        req(2'd3, 0, 0, 1, 0);
        check("r34_first", result, 8'hFF);
        req(2'd3, 0, 0, 1, 0);
        check("r34_wrap", {ovf, result}, 9'h100);

        // saturate on count-down
        req(2'd0, 8'h01, 0, 0, 1);
        req(2'd3, 0, 0, 0, 1);
        req(2'd3, 0, 0, 0, 1);
        check("r35_clamp", {ovf, result}, 9'h100);

        // ADD saturates, acc untouched
        req(2'd1, 8'h80, 8'h90, 0, 1);
        check("r36_add", {ovf, result}, 9'h1FF);
        req(2'd3, 0, 0, 1, 0);
        check("r36_acc", result, 8'h01);

        // backpressure then streaming
        req(2'd0, 8'h05, 0, 0, 0);
        in_valid = 1; op = 2'd2; a = 8'h01; out_ready = 0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 0;
        step();

        // accumulate then reset mid-stream
        req(2'd0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) req(2'd2, 8'h10, 0, 0, 0);
        check("r38_acc", result, 8'h40);
        in_valid = 1; rst_n = 0;
        step();
        check("r38_rst", {out_valid, result}, 9'h000);
        rst_n = 1; in_valid = 0;
        step();

        // en low blocks acceptance but pending output drains
        in_valid = 1; op = 2'd0; a = 8'h07; out_ready = 0;
        step();
        en = 0;
        step();
        out_ready = 1; a = 8'h33;
        step();
        step();
        check("r39_drain", {out_valid, result}, 9'h007);
        en = 1; in_valid = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            en        = ($urandom_range(0, 4) != 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 2'($urandom_range(0, 3));
            a         = 8'($urandom);
            b         = 8'($urandom);
            dir       = $urandom_range(0, 1);
            sat       = $urandom_range(0, 1);
            step();
        end
        rst_n = 1; in_valid = 0;
        step();

        // 16-bit, STEP=3 wrap and clamp
        step16(2'd0, 16'hFFFE, 0, 0);
        step16(2'd3, 0, 1, 0);
        check("r39_w16", {ovf16, res16}, 17'h10001);
        step16(2'd3, 0, 0, 0);
        step16(2'd3, 0, 0, 1);
        step16(2'd0, 16'hFFFD, 0, 0);
        step16(2'd3, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
